// File: rtl/matvec_fetch_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matvec_fetch_mac
// Purpose  : Fetches B and LANES rows of A over Avalon-MM, buffers A rows in
//            per-lane FIFOs, then runs LANES parallel MACs: result = A * B.
//            Optional macro MATVEC_SATURATE_EN: clamp accumulators instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module matvec_fetch_mac #(
    parameter int          DATA_WIDTH = 8,
    parameter int          LANES      = 8,
    parameter int          ACC_WIDTH  = 24,
    parameter int          ADDR_WIDTH = 32,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic                          mem_read,
    input  logic [LANES*DATA_WIDTH-1:0]   mem_readdata,
    input  logic                          mem_readdatavalid,
    input  logic                          mem_waitrequest,
    output logic [LANES*ACC_WIDTH-1:0]    result
);

    localparam int c_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_CNT_W = $clog2(LANES + 1);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(LANES - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FETCH_B = 3'd1;
    localparam logic [2:0] c_ST_FETCH_A = 3'd2;
    localparam logic [2:0] c_ST_EXEC    = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    logic [2:0]                  r_state;
    logic                        r_mem_read;
    logic                        r_outstanding;
    logic [ADDR_WIDTH-1:0]       r_mem_address;
    logic [LANES*DATA_WIDTH-1:0] r_b;
    logic [c_IDX_W-1:0]          r_row;
    logic [c_IDX_W-1:0]          r_k;
    logic [LANES*ACC_WIDTH-1:0]  r_acc;
    logic [LANES*ACC_WIDTH-1:0]  r_result;
    logic [LANES*ACC_WIDTH-1:0]  w_acc_next;

    logic w_start_ok;
    logic w_accept;
    logic w_rdata_ok;

    assign w_start_ok = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_accept   = r_mem_read && !mem_waitrequest;
    // Data is only taken when a read is actually in flight; stray beats drop out here.
    assign w_rdata_ok = r_outstanding && mem_readdatavalid;

    assign busy        = (r_state == c_ST_FETCH_B) || (r_state == c_ST_FETCH_A) ||
                         (r_state == c_ST_EXEC);
    assign done        = (r_state == c_ST_DONE);
    assign mem_read    = r_mem_read;
    assign mem_address = r_mem_address;
    assign result      = r_result;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [LANES*DATA_WIDTH-1:0] r_fifo_row;
            logic [c_CNT_W-1:0]          r_fifo_cnt;
            logic [DATA_WIDTH-1:0]       w_a;
            logic [DATA_WIDTH-1:0]       w_bk;
            logic [2*DATA_WIDTH-1:0]     w_prod;

            // The whole row lands at once; entries are consumed in k order by r_k.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_fifo_cnt <= '0;
                end else if ((r_state == c_ST_FETCH_A) && w_rdata_ok &&
                             (r_row == c_IDX_W'(i)) && (r_fifo_cnt == '0)) begin
                    r_fifo_row <= mem_readdata;
                    r_fifo_cnt <= c_CNT_W'(LANES);
                end else if ((r_state == c_ST_EXEC) && (r_fifo_cnt != '0)) begin
                    r_fifo_cnt <= r_fifo_cnt - 1'b1;
                end
            end

            assign w_a    = r_fifo_row[r_k*DATA_WIDTH +: DATA_WIDTH];
            assign w_bk   = r_b[r_k*DATA_WIDTH +: DATA_WIDTH];
            assign w_prod = w_a * w_bk;

`ifdef MATVEC_SATURATE_EN
            logic [ACC_WIDTH:0] w_sum;
            assign w_sum = {1'b0, r_acc[i*ACC_WIDTH +: ACC_WIDTH]} + (ACC_WIDTH+1)'(w_prod);
            assign w_acc_next[i*ACC_WIDTH +: ACC_WIDTH] =
                w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
            logic [ACC_WIDTH-1:0] w_sum;
            assign w_sum = r_acc[i*ACC_WIDTH +: ACC_WIDTH] + ACC_WIDTH'(w_prod);
            assign w_acc_next[i*ACC_WIDTH +: ACC_WIDTH] = w_sum;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_mem_read    <= 1'b0;
            r_outstanding <= 1'b0;
            r_mem_address <= ADDR_WIDTH'(BASE_ADDR);
            r_b           <= '0;
            r_row         <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            r_result      <= '0;
        end else begin
            if (w_accept) begin
                r_mem_read    <= 1'b0;
                r_outstanding <= 1'b1;
            end
            if (w_rdata_ok) begin
                r_outstanding <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_start_ok) begin
                        r_state       <= c_ST_FETCH_B;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= ADDR_WIDTH'(BASE_ADDR);
                        r_acc         <= '0;
                    end
                end
                c_ST_FETCH_B: begin
                    if (w_rdata_ok) begin
                        r_b           <= mem_readdata;
                        r_state       <= c_ST_FETCH_A;
                        r_row         <= '0;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= r_mem_address + ADDR_WIDTH'(1);
                    end
                end
                c_ST_FETCH_A: begin
                    if (w_rdata_ok) begin
                        if (r_row == c_LAST) begin
                            r_state <= c_ST_EXEC;
                            r_k     <= '0;
                        end else begin
                            r_row         <= r_row + 1'b1;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= r_mem_address + ADDR_WIDTH'(1);
                        end
                    end
                end
                c_ST_EXEC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 1'b1;
                    if (r_k == c_LAST) begin
                        r_result <= w_acc_next;
                        r_state  <= c_ST_DONE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
